// File: rtl/rns_pkg.sv
// Shared constants for the RNS reverse converter: moduli, pairwise inverses,
// dynamic range, and the controller state encoding.
package rns_pkg;

  typedef logic [7:0] residue_t;

  // Moduli shared with the RNS FIR datapath (pairwise coprime, all < 256).
  localparam residue_t B0 = 8'd255;
  localparam residue_t B1 = 8'd254;
  localparam residue_t B2 = 8'd253;
  localparam residue_t B3 = 8'd251;

  localparam int unsigned NUM_RES = 4;

  // Dynamic range M = B0*B1*B2*B3 and the signed split point ceil(M/2).
  localparam logic [33:0] M      = 34'(B0) * 34'(B1) * 34'(B2) * 34'(B3);
  localparam logic [33:0] HALF_M = (M + 34'd1) >> 1;

  localparam logic [2:0] MRC_STEPS   = 3'd6;
  localparam logic [2:0] RECON_STEPS = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MRC   = 3'd1,
    ST_RECON = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Modulus of residue channel k.
  function automatic residue_t modulus(input logic [1:0] k);
    case (k)
      2'd0:    modulus = B0;
      2'd1:    modulus = B1;
      2'd2:    modulus = B2;
      default: modulus = B3;
    endcase
  endfunction

  // INV[i][j] = (B_i)^-1 mod B_j, only the pairs used by MRC (i < j).
  function automatic residue_t inv(input logic [1:0] i, input logic [1:0] j);
    case ({i, j})
      4'b00_01: inv = 8'd1;    // 255 = 1 mod 254
      4'b00_10: inv = 8'd127;  // 255 = 2 mod 253
      4'b00_11: inv = 8'd63;   // 255 = 4 mod 251
      4'b01_10: inv = 8'd1;    // 254 = 1 mod 253
      4'b01_11: inv = 8'd84;   // 254 = 3 mod 251
      4'b10_11: inv = 8'd126;  // 253 = 2 mod 251
      default:  inv = 8'd0;
    endcase
  endfunction

  // MRC step order: (0,1) (0,2) (0,3) (1,2) (1,3) (2,3).
  function automatic logic [1:0] mrc_i(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: mrc_i = 2'd0;
      3'd3, 3'd4:       mrc_i = 2'd1;
      default:          mrc_i = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] mrc_j(input logic [2:0] step);
    case (step)
      3'd0:       mrc_j = 2'd1;
      3'd1, 3'd3: mrc_j = 2'd2;
      default:    mrc_j = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/rns_mod_mulsub.sv
// Combinational modular multiply-subtract: p = ((a - b) mod m) * c mod m.
// Operands are reduced first because b is a residue of a different modulus
// and may exceed m.
module rns_mod_mulsub
  import rns_pkg::*;
(
  input  residue_t a,
  input  residue_t b,
  input  residue_t m,
  input  residue_t c,
  output residue_t p
);

  residue_t    a_red;
  residue_t    b_red;
  logic [8:0]  diff;
  residue_t    diff_red;
  logic [15:0] prod;
  logic [15:0] prod_red;

  // Reduce, subtract with +m bias, multiply by inverse, reduce again.
  always_comb begin
    a_red = a % m;
    b_red = b % m;
    diff  = {1'b0, a_red} + {1'b0, m} - {1'b0, b_red};
    if (diff >= {1'b0, m}) begin
      diff_red = 8'(diff - {1'b0, m});
    end else begin
      diff_red = diff[7:0];
    end
    prod     = {8'b0, diff_red} * {8'b0, c};
    prod_red = prod % {8'b0, m};
    p        = prod_red[7:0];
  end

endmodule

// File: rtl/rns_to_bin.sv
// RNS to binary reverse converter: sequential mixed-radix conversion using
// one shared modular multiply-subtract, then Horner recombination.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | in_ready high, waiting for in_valid
// MRC      | six mixed-radix steps, one residue pair per cycle
// RECON    | three Horner steps building the 34-bit accumulator
// FIX      | signed mapping / error zeroing, raise out_valid
// DONE     | hold y/err until out_ready
module rns_to_bin
  import rns_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_rns,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        err
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  residue_t    r_q [NUM_RES];
  residue_t    r_d [NUM_RES];
  logic [33:0] acc_q, acc_d;
  logic [31:0] y_q, y_d;
  logic        err_q, err_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic        in_err;
  logic [2:0]  mrc_step;
  logic [1:0]  mi;
  logic [1:0]  mj;
  residue_t    ms_a, ms_b, ms_m, ms_c, ms_p;

  logic [2:0]  recon_step;
  logic [33:0] horner_base;
  residue_t    horner_mod;
  residue_t    horner_digit;
  logic [33:0] horner_next;

  // Flag any incoming residue that is out of range for its modulus.
  always_comb begin
    in_err = 1'b0;
    for (int k = 0; k < NUM_RES; k++) begin
      if (x_rns[8*k +: 8] >= modulus(2'(k))) begin
        in_err = 1'b1;
      end
    end
  end

  // Select the residue pair and inverse for the current MRC step.
  always_comb begin
    mrc_step = MRC_STEPS - 3'd1 - cnt_q;
    mi       = mrc_i(mrc_step);
    mj       = mrc_j(mrc_step);
    ms_a     = r_q[mj];
    ms_b     = r_q[mi];
    ms_m     = modulus(mj);
    ms_c     = inv(mi, mj);
  end

  rns_mod_mulsub u_mulsub (
    .a (ms_a),
    .b (ms_b),
    .m (ms_m),
    .c (ms_c),
    .p (ms_p)
  );

  // One Horner step: acc*B + d, seeded from d3 on the first step.
  always_comb begin
    recon_step = RECON_STEPS - 3'd1 - cnt_q;
    case (recon_step)
      3'd0: begin
        horner_base  = 34'(r_q[3]);
        horner_mod   = B2;
        horner_digit = r_q[2];
      end
      3'd1: begin
        horner_base  = acc_q;
        horner_mod   = B1;
        horner_digit = r_q[1];
      end
      default: begin
        horner_base  = acc_q;
        horner_mod   = B0;
        horner_digit = r_q[0];
      end
    endcase
    horner_next = horner_base * 34'(horner_mod) + 34'(horner_digit);
  end

  // Controller next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    acc_d       = acc_q;
    y_d         = y_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (in_ready_q && in_valid) begin
          for (int k = 0; k < NUM_RES; k++) begin
            r_d[k] = x_rns[8*k +: 8];
          end
          err_d      = in_err;
          in_ready_d = 1'b0;
          cnt_d      = MRC_STEPS - 3'd1;
          state_d    = ST_MRC;
        end
      end

      ST_MRC: begin
        r_d[mj] = ms_p;
        if (cnt_q == 3'd0) begin
          cnt_d   = RECON_STEPS - 3'd1;
          state_d = ST_RECON;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_RECON: begin
        acc_d = horner_next;
        if (cnt_q == 3'd0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_FIX: begin
        if (err_q) begin
          y_d = '0;
        end else if (SIGNED && (acc_q >= HALF_M)) begin
          y_d = 32'(acc_q - M);
        end else begin
          y_d = acc_q[31:0];
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      for (int k = 0; k < NUM_RES; k++) begin
        r_q[k] <= '0;
      end
      acc_q       <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rns_to_bin.sv
// Directed bench for rns_to_bin: signed and unsigned instances share stimulus.
module tb_rns_to_bin;

  localparam longint unsigned TB_B0   = 255;
  localparam longint unsigned TB_B1   = 254;
  localparam longint unsigned TB_B2   = 253;
  localparam longint unsigned TB_B3   = 251;
  localparam longint unsigned TB_M    = 64'd4113089310;
  localparam longint unsigned TB_HALF = 64'd2056544655;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] x_rns;
  logic        out_ready;
  logic        in_ready_s, out_valid_s, err_s;
  logic [31:0] y_s;
  logic        in_ready_u, out_valid_u, err_u;
  logic [31:0] y_u;

  int checks   = 0;
  int failures = 0;
  time accept_time;

  rns_to_bin #(.SIGNED(1'b1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .x_rns(x_rns), .out_valid(out_valid_s), .out_ready(out_ready),
    .y(y_s), .err(err_s)
  );

  rns_to_bin #(.SIGNED(1'b0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
    .x_rns(x_rns), .out_valid(out_valid_u), .out_ready(out_ready),
    .y(y_u), .err(err_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pack_res(input longint unsigned v);
    logic [7:0] r0, r1, r2, r3;
    r0 = 8'(v % TB_B0);
    r1 = 8'(v % TB_B1);
    r2 = 8'(v % TB_B2);
    r3 = 8'(v % TB_B3);
    return {r3, r2, r1, r0};
  endfunction

  // Present one word, wait for the accept edge, then count edges to out_valid.
  task automatic do_conv(input logic [31:0] x, output int lat);
    int n;
    n = 0;
    while (in_ready_s !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (in_ready_s !== 1'b1) begin
      checks++; failures++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready_s);
    end
    @(negedge clk);
    in_valid = 1'b1;
    x_rns    = x;
    @(posedge clk);
    accept_time = $time;
    #1;
    in_valid = 1'b0;
    x_rns    = $urandom;
    lat = 0;
    while (out_valid_s !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic pop_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; x_rns = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready_s, out_valid_s, err_s, in_ready_u, out_valid_u, err_u} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {in_ready_s, out_valid_s, err_s, in_ready_u, out_valid_u, err_u});
    end
    checks++;
    if (y_s !== 32'h0 || y_u !== 32'h0) begin
      failures++;
      $display("FAIL reset_y: got %h/%h required 0", y_s, y_u);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL ready_before_edge: got %b required 0", in_ready_s);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready_s !== 1'b1 || in_ready_u !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_release: got %b/%b required 1", in_ready_s, in_ready_u);
    end
  endtask

  task automatic test_zero();
    int lat;
    do_conv(32'h0, lat);
    checks++;
    if (lat !== 10) begin
      failures++;
      $display("FAIL zero_latency: got %0d required 10", lat);
    end
    checks++;
    if (y_s !== 32'h0 || y_u !== 32'h0 || err_s !== 1'b0) begin
      failures++;
      $display("FAIL zero_value: got y=%h/%h err=%b required 0/0 err=0", y_s, y_u, err_s);
    end
    pop_result();
  endtask

  task automatic test_directed();
    logic [31:0] vx [6];
    logic [31:0] vs [6];
    logic [31:0] vu [6];
    int lat;
    vx[0] = 32'h01010101; vs[0] = 32'd1;         vu[0] = 32'd1;
    vx[1] = 32'hF7F1EEEB; vs[1] = 32'd1000;      vu[1] = 32'd1000;
    vx[2] = 32'hFAFCFDFE; vs[2] = 32'hFFFFFFFF;  vu[2] = 32'hF528C31D;
    vx[3] = 32'hCD346596; vs[3] = 32'hFFFFCFC7;  vu[3] = 32'hF52892E5;
    vx[4] = pack_res(TB_HALF - 1); vs[4] = 32'h7A94618E; vu[4] = 32'h7A94618E;
    vx[5] = pack_res(TB_HALF);     vs[5] = 32'h856B9E71; vu[5] = 32'h7A94618F;
    for (int i = 0; i < 6; i++) begin
      do_conv(vx[i], lat);
      checks++;
      if (lat !== 10 || y_s !== vs[i] || err_s !== 1'b0) begin
        failures++;
        $display("FAIL directed_signed[%0d]: got y=%h err=%b lat=%0d required y=%h err=0 lat=10",
                 i, y_s, err_s, lat, vs[i]);
      end
      checks++;
      if (y_u !== vu[i] || err_u !== 1'b0) begin
        failures++;
        $display("FAIL directed_unsigned[%0d]: got y=%h err=%b required y=%h err=0",
                 i, y_u, err_u, vu[i]);
      end
      pop_result();
    end
  endtask

  task automatic test_err();
    int lat;
    do_conv(32'h000000FF, lat);
    checks++;
    if (err_s !== 1'b1 || y_s !== 32'h0 || err_u !== 1'b1 || y_u !== 32'h0) begin
      failures++;
      $display("FAIL err_range: got err=%b/%b y=%h/%h required err=1 y=0", err_s, err_u, y_s, y_u);
    end
    pop_result();
    do_conv(32'hF7F1EEEB, lat);
    checks++;
    if (err_s !== 1'b0 || y_s !== 32'd1000) begin
      failures++;
      $display("FAIL err_recover: got err=%b y=%0d required err=0 y=1000", err_s, y_s);
    end
    pop_result();
  endtask

  task automatic test_backpressure();
    int lat;
    do_conv(32'hCD346596, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_rns    = 32'h01010101;
      @(posedge clk); #1;
      checks++;
      if (out_valid_s !== 1'b1 || y_s !== 32'hFFFFCFC7 || err_s !== 1'b0 || in_ready_s !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got ov=%b y=%h err=%b rdy=%b required ov=1 y=ffffcfc7 err=0 rdy=0",
                 c, out_valid_s, y_s, err_s, in_ready_s);
      end
    end
    in_valid = 1'b0;
    pop_result();
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: got ov=%b rdy=%b required ov=0 rdy=1", out_valid_s, in_ready_s);
    end
  endtask

  task automatic test_back_to_back();
    longint unsigned v;
    logic [31:0] es;
    time prev;
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      v  = longint'($urandom_range(32'hF528C31D, 0));
      es = (v >= TB_HALF) ? 32'(v - TB_M) : 32'(v);
      do_conv(pack_res(v), lat);
      checks++;
      if (y_s !== es || y_u !== 32'(v) || err_s !== 1'b0) begin
        failures++;
        $display("FAIL stream[%0d]: got y=%h/%h err=%b required y=%h/%h err=0",
                 i, y_s, y_u, err_s, es, 32'(v));
      end
      if (i > 0) begin
        checks++;
        if (accept_time - prev !== 120) begin
          failures++;
          $display("FAIL stream_rate[%0d]: got %0t between accepts required 120", i, accept_time - prev);
        end
      end
      prev = accept_time;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    do_conv(32'hF7F1EEEB, lat);
    pop_result();
    @(negedge clk);
    in_valid = 1'b1;
    x_rns    = 32'hFAFCFDFE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (y_s !== 32'h0 || err_s !== 1'b0 || out_valid_s !== 1'b0 || in_ready_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got y=%h err=%b ov=%b rdy=%b required all 0",
               y_s, err_s, out_valid_s, in_ready_s);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_conv(32'hCD346596, lat);
    checks++;
    if (lat !== 10 || y_s !== 32'hFFFFCFC7 || y_u !== 32'hF52892E5 || err_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_next: got y=%h/%h err=%b lat=%0d required y=ffffcfc7/f52892e5 err=0 lat=10",
               y_s, y_u, err_s, lat);
    end
    pop_result();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rns_to_bin.md
Name: rns_to_bin

Overview:
- Reverse converter that sits directly downstream of the RNS FIR filter.
- Takes one packed 4-residue RNS word, {r3,r2,r1,r0} as 8 bits each with residue k at bits [8k+7:8k], and returns the 32-bit two's-complement binary value.
- Uses sequential mixed-radix conversion (MRC) with one modular multiply-subtract per cycle, followed by Horner recombination.
- Non-pipelined, one conversion in flight; valid/ready handshakes on both sides.

Parameters:
- SIGNED, 1, 1: map results >= M/2 to negative (result - M); 0: output the unsigned residue value 0..M-1.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  x_rns holds a word to convert
- in_ready  output  1  block can accept a word
- x_rns  input  32  packed residues {r3,r2,r1,r0}, modulus B3..B0
- out_valid  output  1  y and err are valid
- out_ready  input  1  consumer takes y this cycle
- y  output  32  binary result
- err  output  1  at least one input residue was >= its modulus

Behaviour:
- Reset (reset=0, asynchronous):
  - in_ready=0, out_valid=0, y=0, err=0; FSM goes to IDLE.
  - in_ready rises on the first clock edge after reset releases.
  - Reset mid-conversion aborts the conversion; no partial result is ever presented.
- FSM states: IDLE -> MRC -> RECON -> FIX -> DONE -> IDLE.
- IDLE:
  - in_ready=1, held as a registered output.
  - On an edge with in_valid=1, latch x_rns (edge E0), latch err = OR over k of (rk >= Bk), set in_ready=0, go to MRC.
- MRC, 6 cycles, edges E1..E6, one step per edge in this order:
  - (i,j) = (0,1), (0,2), (0,3), (1,2), (1,3), (2,3).
  - Each step: r_j <= ((r_j - r_i) mod B_j) * INV[i][j] mod B_j.
  - Subtraction adds B_j before the modulo, so it never underflows.
  - Afterwards the digits are d0=r0, d1=r1, d2=r2, d3=r3.
- RECON, 3 cycles, edges E7..E9, Horner evaluation:
  - acc = d3.
  - acc = acc*B2 + d2.
  - acc = acc*B1 + d1.
  - acc = acc*B0 + d0.
  - acc is 34 bits wide; M = B0*B1*B2*B3 can reach 2^32.
- FIX, edge E10:
  - If SIGNED and acc >= HALF_M (= ceil(M/2)): y <= acc - M, truncated to 32 bits. Otherwise y <= acc[31:0].
  - If err=1: y <= 0, err held at 1.
  - out_valid <= 1; go to DONE.
- Latency: x_rns accepted at E0 gives out_valid=1 after E10 (10 cycles).
- DONE:
  - y and err are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid <= 0, in_ready <= 1, go to IDLE.
- Throughput: the next accept is at the earliest at E12 when out_ready=1 at E11, giving 12 cycles per word.
- Input rules:
  - in_valid while in_ready=0 is ignored; the producer must hold the word.
  - x_rns is sampled only at the accepting edge; later changes have no effect.
  - out_ready while out_valid=0 is ignored.
- Arithmetic: all intermediate modular products fit in 16 bits, since residue and inverse are each < 256.

Decomposition:
- Package rns_pkg holds:
  - moduli B0..B3, taken from the same constants common.sv uses for the FIR;
  - INV[i][j], the inverse of B_i modulo B_j, precomputed;
  - M, HALF_M (34 bits);
  - FSM state enum.
- Sub-module rns_mod_mulsub: combinational ((a - b) mod m) * c mod m, 8-bit operands. Instantiated once and time-shared by the MRC steps.

Test Plan:
- x_rns=0 after reset -> out_valid rises exactly 10 edges after accept; y=0, err=0.
- Residues of 1 ({1,1,1,1}) -> y=1. Residues of 1000 (1000 mod Bk packed) -> y=1000.
- Residues of M-1 (Bk-1 per field):
  - SIGNED=1 -> y=32'hFFFF_FFFF (-1).
  - SIGNED=0 -> y=M-1.
  - Also residues of -12345 -> y=-12345.
- r0 field = B0 (out of range) -> err=1, y=0. Then a legal word -> err=0 and a correct y.
- Backpressure: hold out_ready=0 for 5 cycles -> y, err and out_valid stable, in_ready=0. Then out_ready=1 -> in_ready=1 on the next edge; a back-to-back stream of 20 random values all convert correctly.
- Assert reset=0 at E5 of a conversion -> outputs zero immediately (asynchronously). After release the next conversion is correct, with no stale result.
